// File: rtl/twos_complement_serial_if.sv
// Handshake bus for the bit-serial two's complement unit.
// master drives operands and consumes results; slave is the unit itself.
interface twos_complement_serial_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] b;
  logic             ovf;

  modport master (
    output in_valid, a, mode, out_ready,
    input  in_ready, out_valid, b, ovf
  );

  modport slave (
    input  in_valid, a, mode, out_ready,
    output in_ready, out_valid, b, ovf
  );
endinterface

// File: rtl/twos_complement_serial.sv
// Bit-serial pass / negate / abs / saturating-negate, LSB first, one bit per clock.
// Result and overflow are published together when the last bit has been processed.
module twos_complement_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  twos_complement_serial_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             seen;
  logic             neg_q;
  logic             sat_q;
  logic [WIDTH-1:0] b_q;
  logic             ovf_q;

  logic             abit;
  logic             obit;
  logic             last;
  logic             is_min;

  assign abit   = sr[0];
  assign obit   = (neg_q && seen) ? ~abit : abit;
  assign last   = (cnt == CW'(WIDTH - 1));
  // Final bit set with all lower bits clear means the operand is the most negative value.
  assign is_min = neg_q & abit & ~seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = SHIFT;
      SHIFT:   if (last)          state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr    <= '0;
      res   <= '0;
      cnt   <= '0;
      seen  <= 1'b0;
      neg_q <= 1'b0;
      sat_q <= 1'b0;
      b_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sr    <= bus.a;
            neg_q <= bus.mode[0] | (bus.mode[1] & bus.a[WIDTH-1]);
            sat_q <= &bus.mode;
            cnt   <= '0;
            seen  <= 1'b0;
          end
        end
        SHIFT: begin
          sr   <= sr >> 1;
          res  <= {obit, res[WIDTH-1:1]};
          seen <= seen | abit;
          cnt  <= cnt + CW'(1);
          if (last) begin
            if (is_min && sat_q) b_q <= {1'b0, {(WIDTH-1){1'b1}}};
            else                 b_q <= {obit, res[WIDTH-1:1]};
            ovf_q <= is_min;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.b   = b_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_twos_complement_serial.sv
// Directed and swept checks of twos_complement_serial at WIDTH=8.
module tb_twos_complement_serial;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  twos_complement_serial_if #(.WIDTH(8)) bus ();

  twos_complement_serial #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ref_op(input logic [7:0] x, input logic [1:0] m);
    logic neg;
    neg = (m == 2'b01) || (m == 2'b11) || ((m == 2'b10) && x[7]);
    if (!neg)        return {1'b0, x};
    if (x == 8'h80)  return {1'b1, (m == 2'b11) ? 8'h7F : 8'h80};
    return {1'b0, 8'(8'h00 - x)};
  endfunction

  // Called between edges; returns #1 after the edge that releases the result.
  task automatic run_op(input logic [7:0] av, input logic [1:0] mv, input logic [7:0] eb,
                        input logic eo, input bit toggle, input string tag);
    int           lat;
    logic [7:0]   b_before;
    bit           held;
    check({tag, "/in_ready"}, bus.in_ready, 1);
    b_before     = bus.b;
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.mode     = mv;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat  = 0;
    held = 1'b1;
    while (!bus.out_valid && lat < 20) begin
      if (toggle) begin
        bus.a        = 8'($urandom);
        bus.mode     = 2'($urandom);
        bus.in_valid = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (!bus.out_valid && bus.b !== b_before) held = 1'b0;
    end
    bus.in_valid = 1'b0;
    check({tag, "/latency"}, lat, 8);
    check({tag, "/b"}, bus.b, eb);
    check({tag, "/ovf"}, bus.ovf, eo);
    check({tag, "/b_hold"}, held, 1);
    @(posedge clk); #1;
    check({tag, "/out_valid_drop"}, bus.out_valid, 0);
    check({tag, "/ready_again"}, bus.in_ready, 1);
  endtask

  initial begin
    int       lat;
    bit       spurious;
    logic [8:0] r;
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.mode      = '0;
    bus.out_ready = 1'b1;

    #1;
    check("rst/b", bus.b, 0);
    check("rst/ovf", bus.ovf, 0);
    check("rst/out_valid", bus.out_valid, 0);
    check("rst/in_ready", bus.in_ready, 1);

    #11 rst = 1'b0;
    run_op(8'h05, 2'b01, 8'hFB, 1'b0, 1'b0, "neg05");
    run_op(8'h80, 2'b10, 8'h80, 1'b1, 1'b0, "abs80");
    run_op(8'h7F, 2'b10, 8'h7F, 1'b0, 1'b0, "abs7F");
    run_op(8'hF6, 2'b10, 8'h0A, 1'b0, 1'b0, "absF6");
    run_op(8'h00, 2'b01, 8'h00, 1'b0, 1'b0, "neg00");
    run_op(8'hA5, 2'b00, 8'hA5, 1'b0, 1'b0, "passA5");
    run_op(8'h80, 2'b00, 8'h80, 1'b0, 1'b0, "pass80");
    run_op(8'h80, 2'b01, 8'h80, 1'b1, 1'b0, "neg80");
    run_op(8'h00, 2'b11, 8'h00, 1'b0, 1'b0, "sat00");

    // Result held under backpressure; in_valid pulses ignored outside IDLE.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 8'h01;
    bus.mode      = 2'b01;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp/latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'(i);
      bus.a        = 8'h33;
      bus.mode     = 2'b01;
      @(posedge clk); #1;
      check("bp/b", bus.b, 8'hFF);
      check("bp/out_valid", bus.out_valid, 1);
      check("bp/in_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp/release_valid", bus.out_valid, 0);
    check("bp/no_accept_on_release", bus.in_ready, 1);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp/idle_after", bus.in_ready, 1);
    run_op(8'h02, 2'b01, 8'hFE, 1'b0, 1'b0, "after_bp");

    run_op(8'h80, 2'b11, 8'h7F, 1'b1, 1'b0, "sat80");

    // Reset in the middle of a shift discards the operation.
    bus.in_valid = 1'b1;
    bus.a        = 8'h10;
    bus.mode     = 2'b01;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #1 rst = 1'b1;
    #1;
    check("midrst/out_valid", bus.out_valid, 0);
    check("midrst/b", bus.b, 0);
    check("midrst/ovf", bus.ovf, 0);
    check("midrst/in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    spurious = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.out_valid) spurious = 1'b1;
    end
    check("midrst/no_result", spurious, 0);
    run_op(8'h02, 2'b01, 8'hFE, 1'b0, 1'b0, "post_rst");

    // Full sweep with inputs scrambled while shifting.
    for (int unsigned m = 0; m < 4; m++) begin
      for (int unsigned v = 0; v < 256; v++) begin
        r = ref_op(8'(v), 2'(m));
        run_op(8'(v), 2'(m), r[7:0], r[8], 1'b1, "sweep");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/twos_complement_serial.md
TWOS_COMPLEMENT_SERIAL -- requirements
Module: twos_complement_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand and mode present on a/mode.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand this cycle.
REQ-006 SHALL have port a  input  WIDTH  operand, two's complement signed.
REQ-007 SHALL have port mode  input  2  operation: 00 pass, 01 negate, 10 absolute value, 11 saturating negate.
REQ-008 SHALL have port out_valid  output  1  result on b/ovf is valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result this cycle.
REQ-010 SHALL have port b  output  WIDTH  result.
REQ-011 SHALL have port ovf  output  1  result not representable; qualified by out_valid.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, SHIFT, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE.
REQ-014 Accept: in IDLE with in_valid=1 at a rising edge, a and mode SHALL be captured, bit counter cleared, seen-one flag cleared, and the FSM SHALL enter SHIFT.
REQ-015 In SHIFT, SHALL process one bit per cycle, LSB first, bit index = counter (0..WIDTH-1).
REQ-016 Negation rule per bit: out bit = a bit while seen-one=0, else inverted a bit; seen-one |= a bit after each bit.
REQ-017 Negation SHALL be applied for mode 01 and 11 always; for mode 10 only when captured a[WIDTH-1]=1; never for mode 00.
REQ-018 After the bit at index WIDTH-1 is processed, FSM SHALL enter DONE; out_valid SHALL rise exactly WIDTH clock edges after the accepting edge.
REQ-019 ovf SHALL be 1 when negation applied and captured a = 1 followed by WIDTH-1 zeros (most negative value); otherwise 0.
REQ-020 Mode 11 with the most negative input SHALL output b = 0 followed by WIDTH-1 ones (max positive) with ovf=1; modes 01/10 output b equal to the input with ovf=1.
REQ-021 Input 0 in any negating mode SHALL give b=0, ovf=0.
REQ-022 In DONE, out_valid=1 and b/ovf SHALL stay stable until out_ready=1 at a rising edge; then FSM SHALL return to IDLE and out_valid drop to 0.
REQ-023 in_valid while not in IDLE SHALL be ignored with no effect on the operation in progress.
REQ-024 In DONE, out_ready=1 and in_valid=1 in the same cycle SHALL NOT accept the new operand; it is accepted no earlier than the next cycle in IDLE (throughput one operand per WIDTH+2 cycles minimum).
REQ-025 Changes on a/mode after the accepting edge SHALL NOT affect the result.
REQ-026 b SHALL hold its previous value in IDLE and SHIFT; only internal shift registers change during SHIFT.

Reset
REQ-027 rst=1 SHALL asynchronously force FSM to IDLE, counter 0, seen-one 0, b=0, ovf=0, out_valid=0, in_ready=1 after release.
REQ-028 Reset during SHIFT or DONE SHALL discard the operation; no out_valid for it after release.
REQ-029 First accept after rst deasserts SHALL be possible on the first rising edge with rst=0.

Verification (WIDTH=8)
REQ-030 mode=01, a=0x05, out_ready=1 -> out_valid 8 edges after accept, b=0xFB, ovf=0; in_ready=1 again next cycle.
REQ-031 mode=10, a=0x80 -> b=0x80, ovf=1; mode=10, a=0x7F -> b=0x7F, ovf=0; mode=10, a=0xF6 -> b=0x0A.
REQ-032 mode=11, a=0x80 -> b=0x7F, ovf=1; mode=01, a=0x00 -> b=0x00, ovf=0; mode=00, a=0xA5 -> b=0xA5.
REQ-033 mode=01, a=0x01, out_ready=0 for 5 cycles after out_valid -> b=0xFF held stable, in_ready=0, in_valid pulses with a=0x33 ignored; after out_ready=1, next result belongs only to later accepted operands.
REQ-034 Accept a=0x10 mode=01, assert rst at counter=3 -> out_valid, b, ovf all 0 immediately; after release, a=0x02 mode=01 -> b=0xFE with latency 8.
REQ-035 Exhaustive sweep all 256 a values x 4 modes compared against a reference model, including a/mode toggling during SHIFT.
